alu_sequencer: RTL

Sequencer that drives the team's 4-bit ALU (A, B, 3-bit operation -> 4-bit result) through a selectable set of operations for one latched operand pair. It registers each result and holds it stable for a fixed number of cycles so the downstream display stage can show it. It sits between the operand/control source (switches or a test bench) and the ALU + display pair. It replaces the hand-stepped operation sweep with a start/done handshake.

---
 rtl/alu_sequencer_if.sv | 29 ++
 rtl/alu_sequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// Operand, control and result bundle between the operand source, the ALU sequencer and the ALU/display pair.
interface alu_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
);
  logic                  start;
  logic [WIDTH-1:0]      a_in;
  logic [WIDTH-1:0]      b_in;
  logic [2**OPW-1:0]     op_mask;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [OPW-1:0]        alu_op;
  logic [WIDTH-1:0]      alu_result;
  logic [WIDTH-1:0]      res_data;
  logic [OPW-1:0]        res_op;
  logic                  res_valid;
  logic                  busy;
  logic                  done;

  modport master (
    output start, a_in, b_in, op_mask, alu_result,
    input  alu_a, alu_b, alu_op, res_data, res_op, res_valid, busy, done
  );

  modport slave (
    input  start, a_in, b_in, op_mask, alu_result,
    output alu_a, alu_b, alu_op, res_data, res_op, res_valid, busy, done
  );
endinterface

// File: rtl/alu_sequencer.sv
// Steps a combinational ALU through the selected operations for one latched operand pair,
// holding each captured result for HOLD_CYCLES cycles and signalling completion with done.
module alu_sequencer #(
  parameter int WIDTH       = 4,
  parameter int OPW         = 3,
  parameter int HOLD_CYCLES = 10
) (
  input  logic           clk,
  input  logic           reset,
  alu_sequencer_if.slave bus
);
  localparam int NOPS = 2**OPW;
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [NOPS-1:0]   mask_r, mask_s;
  logic [WIDTH-1:0]  alu_a_r, alu_a_s, alu_b_r, alu_b_s;
  logic [OPW-1:0]    alu_op_r, alu_op_s;
  logic [WIDTH-1:0]  res_data_r, res_data_s;
  logic [OPW-1:0]    res_op_r, res_op_s;
  logic              res_valid_r, res_valid_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic [7:0]        cnt_r, cnt_s;

  function automatic logic [OPW-1:0] lowest_set(input logic [NOPS-1:0] m);
    logic [OPW-1:0] idx;
    idx = {OPW{1'b0}};
    for (int i = NOPS - 1; i >= 0; i--) begin
      if (m[i]) idx = OPW'(i);
    end
    return idx;
  endfunction

  // Next-state and next-output computation; every output is registered from these values.
  always_comb begin
    state_s     = state_r;
    mask_s      = mask_r;
    alu_a_s     = alu_a_r;
    alu_b_s     = alu_b_r;
    alu_op_s    = alu_op_r;
    res_data_s  = res_data_r;
    res_op_s    = res_op_r;
    res_valid_s = 1'b0;
    cnt_s       = cnt_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          alu_a_s = bus.a_in;
          alu_b_s = bus.b_in;
          mask_s  = bus.op_mask;
          if (bus.op_mask != {NOPS{1'b0}}) begin
            alu_op_s = lowest_set(bus.op_mask);
            state_s  = ISSUE;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        res_data_s  = bus.alu_result;
        res_op_s    = alu_op_r;
        mask_s      = mask_r & ~({{(NOPS-1){1'b0}}, 1'b1} << alu_op_r);
        cnt_s       = HOLD_LOAD;
        res_valid_s = 1'b1;
        state_s     = HOLD;
      end
      HOLD: begin
        // The bit of the op just issued is already cleared, so lowest_set yields the next op.
        if (cnt_r <= 8'd1) begin
          if (mask_r != {NOPS{1'b0}}) begin
            alu_op_s = lowest_set(mask_r);
            state_s  = ISSUE;
          end else begin
            state_s = DONE;
          end
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s == ISSUE) || (state_s == HOLD);
    done_s = (state_s == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      mask_r      <= {NOPS{1'b0}};
      alu_a_r     <= {WIDTH{1'b0}};
      alu_b_r     <= {WIDTH{1'b0}};
      alu_op_r    <= {OPW{1'b0}};
      res_data_r  <= {WIDTH{1'b0}};
      res_op_r    <= {OPW{1'b0}};
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cnt_r       <= 8'd0;
    end else begin
      state_r     <= state_s;
      mask_r      <= mask_s;
      alu_a_r     <= alu_a_s;
      alu_b_r     <= alu_b_s;
      alu_op_r    <= alu_op_s;
      res_data_r  <= res_data_s;
      res_op_r    <= res_op_s;
      res_valid_r <= res_valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      cnt_r       <= cnt_s;
    end
  end

  assign bus.alu_a     = alu_a_r;
  assign bus.alu_b     = alu_b_r;
  assign bus.alu_op    = alu_op_r;
  assign bus.res_data  = res_data_r;
  assign bus.res_op    = res_op_r;
  assign bus.res_valid = res_valid_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
endmodule
